sci_tx_framer: RTL

Upstream feeder for the byte-level SCI transmitter. It accepts 16-bit result words from the NN core, buffers them in a small FIFO, and wraps each word in a 4-byte frame: header, high byte, low byte, checksum. It presents the frame bytes one at a time on the transmitter's `tx_data`/`tx_start`/`tx_ready` handshake. It runs entirely in the `baud_clk` domain.

---
 rtl/sci_tx_framer_pkg.sv | 29 ++
 rtl/sci_word_fifo.sv | 82 ++++++++
 rtl/sci_tx_framer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sci_tx_framer_pkg.sv
// Shared types and constants for the SCI transmit framer.
// State encodings, default header and frame length live here.
package sci_tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4
    } sci_state_e;

    localparam logic [7:0] SCI_HDR_DEFAULT = 8'hA5;
    localparam int         SCI_FRAME_BYTES = 4;

    typedef logic [1:0] sci_idx_t;

    localparam sci_idx_t SCI_LAST_IDX = sci_idx_t'(SCI_FRAME_BYTES - 1);

    // Frame checksum: 8-bit sum, carries discarded.
    function automatic logic [7:0] sci_checksum(
        input logic [7:0] hdr,
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        return hdr + hi + lo;
    endfunction

endpackage

// File: rtl/sci_word_fifo.sv
// Circular word FIFO feeding the SCI framer.
// Reports count/full/empty and a sticky overflow flag.
module sci_word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     baud_clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign ovf     = ovf_q;

    // Next-state for storage, pointers, occupancy and overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state register; reset empties the buffer.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/sci_tx_framer.sv
// Wraps each buffered 16-bit word into a 4-byte SCI frame
// and hands the bytes to the UART on a start/ready handshake.
module sci_tx_framer
    import sci_tx_framer_pkg::*;
#(
    parameter int         DEPTH = 8,
    parameter logic [7:0] HDR   = SCI_HDR_DEFAULT
) (
    input  logic                   baud_clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   busy,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_ready
);

    sci_state_e  state_q, state_d;
    sci_idx_t    idx_q, idx_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  ck_q, ck_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        busy_q, busy_d;
    logic        rd_en;
    logic        fifo_empty;
    logic [15:0] head;

    sci_word_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .baud_clk (baud_clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (head),
        .count    (count),
        .full     (full),
        .empty    (fifo_empty),
        .ovf      (ovf)
    );

    function automatic logic [7:0] frame_byte(
        input sci_idx_t   idx,
        input logic [7:0] hi,
        input logic [7:0] lo,
        input logic [7:0] ck
    );
        logic [7:0] b;
        b = ck;
        unique case (idx)
            2'd0: b = HDR;
            2'd1: b = hi;
            2'd2: b = lo;
            2'd3: b = ck;
        endcase
        return b;
    endfunction

    // Frame sequencer; tx_data/tx_start are registered on entry to SEND.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        ck_d       = ck_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        rd_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && tx_ready) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rd_en      = 1'b1;
                hi_d       = head[15:8];
                lo_d       = head[7:0];
                ck_d       = sci_checksum(HDR, head[15:8], head[7:0]);
                idx_d      = '0;
                tx_data_d  = HDR;
                tx_start_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_ready) begin
                    if (idx_q == SCI_LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d      = idx_q + sci_idx_t'(1);
                        tx_data_d  = frame_byte(idx_d, hi_q, lo_q, ck_q);
                        tx_start_d = 1'b1;
                        state_d    = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer and output registers; reset abandons any frame.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            ck_q       <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            ck_q       <= ck_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;

endmodule
